uart_image_loader: RTL
======================

// Module: uart_image_loader
// PURPOSE
//  Parametrised UART receiver plus image-buffer write sequencer; generalises the
//  fixed 8N1 input path feeding the NN core. Deserialises rx bytes, checks
//  framing/parity, writes each accepted pixel to image RAM at sequential addresses.
//  Flags image_written once IMG_PIXELS pixels are stored, for the inference FSM.
// PARAMETERS
//  CLKS_PER_BIT  4    clk cycles per UART bit (>=4); 40 ns bit at 10 ns clk
//  DATA_BITS     8    data bits per frame (5..8); stored LSB-aligned, zero-extended
//  PARITY_MODE   0    0 none, 1 even, 2 odd
//  IMG_PIXELS    784  pixels per image (28x28)
//  ADDR_W        10   image RAM address width; 2**ADDR_W >= IMG_PIXELS
// PORTS
//  clk           in   1       system clock
//  reset         in   1       asynchronous, active-high reset
//  rx            in   1       UART serial input, idle high, LSB first
//  read_request  in   1       1 = accept pixels; 0 = received bytes discarded
//  image_clear   in   1       1-cycle pulse: rearm for a new image
//  wr_en         out  1       1-cycle RAM write strobe
//  wr_addr       out  ADDR_W  RAM write address (pixel index)
//  wr_data       out  8       pixel value
//  image_written out  1       level: IMG_PIXELS pixels stored
//  pixel_count   out  ADDR_W+1 pixels stored so far
//  frame_err     out  1       1-cycle pulse: stop bit sampled low
//  parity_err    out  1       1-cycle pulse: parity mismatch
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters 0; rx synchroniser preset to 1.
//  rx passes a 2-FF synchroniser; all sampling uses the synchronised value.
//  FSM: IDLE -> START on sync rx=0. START: at CLKS_PER_BIT/2 resample; 1 = glitch
//   -> IDLE, 0 -> DATA. DATA: sample every CLKS_PER_BIT (bit centre), shift LSB
//   first, DATA_BITS samples -> PARITY (if PARITY_MODE!=0) else STOP.
//   PARITY: one centre sample -> STOP. STOP: one centre sample.
//   Stop=1 -> IDLE (next start detectable the following cycle).
//   Stop=0 -> frame_err pulse, byte dropped, WAIT_IDLE until sync rx=1, then IDLE.
//  Parity: even = XOR(data,parity)=0; odd = XOR=1. Mismatch -> parity_err pulse,
//   byte dropped; frame check still done; both errors may pulse together.
//  Accept: valid byte with read_request=1 and image_written=0 -> wr_en=1 for one
//   cycle, the cycle after the stop-bit sample; wr_addr = pixel_count (pre-increment),
//   wr_data = byte; pixel_count increments same edge.
//  Valid byte with read_request=0 or image_written=1: dropped silently, no error.
//  Completion: the write with pixel_count = IMG_PIXELS-1 sets image_written on the
//   next edge; it holds until image_clear or reset; pixel_count saturates.
//  image_clear: pixel_count<=0, image_written<=0; UART FSM unaffected. If clear
//   coincides with a write strobe, clear wins: write suppressed, count 0.
//  Reset mid-frame: frame abandoned, no write; loading restarts at address 0.
//  Pixels are written verbatim; signedness is the consumer's concern.
// TESTING
//  1 Defaults, 784 8N1 frames (40 ns bits), data 0..127 pattern -> 784 wr_en
//    pulses, wr_addr 0..783, wr_data matches; image_written=1 one cycle after last.
//  2 785th frame after completion -> no wr_en; pixel_count stays 784; no err pulse.
//  3 Frame 0xA5 with stop bit 0, then good 0x3C -> frame_err 1 pulse, no write;
//    0x3C written at addr 0 once rx returns high and a new start arrives.
//  4 PARITY_MODE=1: 0x07 with parity 1 -> written; 0x07 with parity 0 ->
//    parity_err pulse, not written, pixel_count unchanged.
//  5 0-pulse of CLKS_PER_BIT/2-1 cycles on idle rx -> no write, no errors.
//  6 image_clear during 10th byte's write cycle -> write suppressed,
//    pixel_count=0; reset mid-byte -> all outputs 0, next frame to addr 0.

Source files
------------

// File: rtl/uart_image_loader.sv
// UART receiver (configurable data bits and parity) that writes each accepted byte
// into image RAM at sequential addresses and flags when a full image is stored.
module uart_image_loader #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_MODE  = 0,
    parameter int IMG_PIXELS   = 784,
    parameter int ADDR_W       = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx,
    input  logic              read_request,
    input  logic              image_clear,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              image_written,
    output logic [ADDR_W:0]   pixel_count,
    output logic              frame_err,
    output logic              parity_err
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0]   CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(DATA_BITS - 1);
    localparam logic [ADDR_W:0] PIX_LAST = (ADDR_W + 1)'(IMG_PIXELS - 1);
    localparam logic            PAR_ODD  = (PARITY_MODE == 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_IDLE
    } state_t;

    state_t               state, state_next;
    logic                 rx_meta, rx_sync;
    logic [CW-1:0]        clk_cnt, clk_cnt_next;
    logic [BW-1:0]        bit_cnt, bit_cnt_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par_bit, par_bit_next;
    logic                 byte_done, stop_bad, par_bad, par_mismatch;
    logic                 wr_pending;
    logic [7:0]           byte_ext;

    // Synchroniser presets to idle-high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
        end else begin
            state   <= state_next;
            clk_cnt <= clk_cnt_next;
            bit_cnt <= bit_cnt_next;
            shreg   <= shreg_next;
            par_bit <= par_bit_next;
        end
    end

    assign par_mismatch = (PARITY_MODE != 0) && ((^shreg ^ par_bit) != PAR_ODD);

    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_cnt_next = bit_cnt;
        shreg_next   = shreg;
        par_bit_next = par_bit;
        byte_done    = 1'b0;
        stop_bad     = 1'b0;
        par_bad      = 1'b0;
        byte_ext     = '0;
        byte_ext[DATA_BITS-1:0] = shreg;

        case (state)
            S_IDLE: begin
                clk_cnt_next = '0;
                bit_cnt_next = '0;
                if (!rx_sync) state_next = S_START;
            end
            S_START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_next = '0;
                    state_next   = rx_sync ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_next = '0;
                    shreg_next   = {rx_sync, shreg[DATA_BITS-1:1]};
                    bit_cnt_next = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST)
                        state_next = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            S_PARITY: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_next = '0;
                    par_bit_next = rx_sync;
                    state_next   = S_STOP;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (clk_cnt == CNT_FULL) begin
                    clk_cnt_next = '0;
                    byte_done    = rx_sync;
                    stop_bad     = !rx_sync;
                    par_bad      = par_mismatch;
                    state_next   = rx_sync ? S_IDLE : S_WAIT_IDLE;
                end else begin
                    clk_cnt_next = clk_cnt + 1'b1;
                end
            end
            S_WAIT_IDLE: begin
                if (rx_sync) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // A write is queued at the stop sample and issued the following cycle,
    // unless image_clear lands on that cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_pending    <= 1'b0;
            wr_data       <= '0;
            image_written <= 1'b0;
            pixel_count   <= '0;
            frame_err     <= 1'b0;
            parity_err    <= 1'b0;
        end else begin
            frame_err  <= stop_bad;
            parity_err <= par_bad;
            wr_pending <= byte_done && !par_bad && read_request && !image_written;
            if (byte_done && !par_bad && read_request && !image_written)
                wr_data <= byte_ext;
            if (image_clear) begin
                pixel_count   <= '0;
                image_written <= 1'b0;
            end else if (wr_pending && !image_written) begin
                pixel_count <= pixel_count + 1'b1;
                if (pixel_count == PIX_LAST) image_written <= 1'b1;
            end
        end
    end

    assign wr_en   = wr_pending && !image_clear;
    assign wr_addr = pixel_count[ADDR_W-1:0];

endmodule
